// File: rtl/cu_pkg.sv
// Shared control-unit definitions for the RV32I decode stage, signExtender and ALU:
// the cuOPType encoding, opcode / funct3 / funct7 constants, and the decoded-entry record.
package cu_pkg;

   // cuOPType; the value order is the encoding seen by downstream consumers.
   typedef enum logic [5:0] {
      CU_LUI, CU_AUIPC, CU_JAL, CU_JALR,
      CU_BEQ, CU_BNE, CU_BLT, CU_BGE, CU_BLTU, CU_BGEU,
      CU_LB, CU_LH, CU_LW, CU_LBU, CU_LHU,
      CU_SB, CU_SH, CU_SW,
      CU_ADDI, CU_SLTI, CU_SLTIU, CU_XORI, CU_ORI, CU_ANDI,
      CU_SLLI, CU_SRLI, CU_SRAI,
      CU_ADD, CU_SUB, CU_SLL, CU_SLT, CU_SLTU, CU_XOR, CU_SRL, CU_SRA, CU_OR, CU_AND,
      CU_ERROR
   } cu_op_e;

   // Instruction format, selects immediate packing and which register fields are live.
   typedef enum logic [2:0] {
      FMT_NONE, FMT_U, FMT_I, FMT_SHAMT, FMT_S, FMT_B, FMT_R
   } fmt_e;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [2:0] F3_JALR = 3'b000;
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;
   localparam logic [2:0] F3_B    = 3'b000;
   localparam logic [2:0] F3_H    = 3'b001;
   localparam logic [2:0] F3_W    = 3'b010;
   localparam logic [2:0] F3_BU   = 3'b100;
   localparam logic [2:0] F3_HU   = 3'b101;
   // ALU funct3 values, common to OP and OP-IMM.
   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   // One decoded entry as held in the stage's output and skid registers.
   typedef struct packed {
      cu_op_e      cu_op;
      logic [19:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        illegal;
   } decoded_t;

   localparam decoded_t DECODED_RESET = '{
      cu_op: CU_ERROR, imm: 20'd0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0, illegal: 1'b0
   };

   // Format implied by an operation; CU_ERROR has no format, so all fields stay zero.
   function automatic fmt_e fmt_of(cu_op_e op);
      case (op)
         CU_LUI, CU_AUIPC, CU_JAL:                        return FMT_U;
         CU_JALR, CU_LB, CU_LH, CU_LW, CU_LBU, CU_LHU,
         CU_ADDI, CU_SLTI, CU_SLTIU, CU_XORI, CU_ORI,
         CU_ANDI:                                         return FMT_I;
         CU_SLLI, CU_SRLI, CU_SRAI:                       return FMT_SHAMT;
         CU_SB, CU_SH, CU_SW:                             return FMT_S;
         CU_BEQ, CU_BNE, CU_BLT, CU_BGE, CU_BLTU, CU_BGEU: return FMT_B;
         CU_ADD, CU_SUB, CU_SLL, CU_SLT, CU_SLTU, CU_XOR,
         CU_SRL, CU_SRA, CU_OR, CU_AND:                   return FMT_R;
         default:                                         return FMT_NONE;
      endcase
   endfunction

endpackage

// File: rtl/insn_classify.sv
// Pure combinational RV32I classifier: instruction word -> cuOPType, raw packed
// immediate and the register indices the format actually uses.
module insn_classify
   import cu_pkg::*;
(
   input  logic [31:0] instr_i,
   output cu_op_e      cu_op_o,
   output logic [19:0] imm_o,
   output logic [4:0]  rs1_o,
   output logic [4:0]  rs2_o,
   output logic [4:0]  rd_o
);

   logic [6:0] opcode;
   logic [2:0] f3;
   logic [6:0] f7;
   cu_op_e     op;
   fmt_e       fmt;

   assign opcode = instr_i[6:0];
   assign f3     = instr_i[14:12];
   assign f7     = instr_i[31:25];
   assign fmt    = fmt_of(op);

   // Operation select from opcode / funct3 / funct7; anything unlisted stays CU_ERROR.
   always_comb begin
      // NOTE: the default assigned first covers every unlisted path, so no latch is inferred.
      op = CU_ERROR;
      case (opcode)
         OPC_LUI:   op = CU_LUI;
         OPC_AUIPC: op = CU_AUIPC;
         OPC_JAL:   op = CU_JAL;
         OPC_JALR:  if (f3 == F3_JALR) op = CU_JALR;
         OPC_BRANCH:
            case (f3)
               F3_BEQ:  op = CU_BEQ;
               F3_BNE:  op = CU_BNE;
               F3_BLT:  op = CU_BLT;
               F3_BGE:  op = CU_BGE;
               F3_BLTU: op = CU_BLTU;
               F3_BGEU: op = CU_BGEU;
               default: op = CU_ERROR;
            endcase
         OPC_LOAD:
            case (f3)
               F3_B:    op = CU_LB;
               F3_H:    op = CU_LH;
               F3_W:    op = CU_LW;
               F3_BU:   op = CU_LBU;
               F3_HU:   op = CU_LHU;
               default: op = CU_ERROR;
            endcase
         OPC_STORE:
            case (f3)
               F3_B:    op = CU_SB;
               F3_H:    op = CU_SH;
               F3_W:    op = CU_SW;
               default: op = CU_ERROR;
            endcase
         OPC_OP_IMM:
            case (f3)
               F3_ADD:  op = CU_ADDI;
               F3_SLT:  op = CU_SLTI;
               F3_SLTU: op = CU_SLTIU;
               F3_XOR:  op = CU_XORI;
               F3_OR:   op = CU_ORI;
               F3_AND:  op = CU_ANDI;
               F3_SLL:  if (f7 == F7_BASE) op = CU_SLLI;
               F3_SR: begin
                  if (f7 == F7_BASE)     op = CU_SRLI;
                  else if (f7 == F7_ALT) op = CU_SRAI;
               end
               default: op = CU_ERROR;
            endcase
         OPC_OP:
            if (f7 == F7_BASE) begin
               case (f3)
                  F3_ADD:  op = CU_ADD;
                  F3_SLL:  op = CU_SLL;
                  F3_SLT:  op = CU_SLT;
                  F3_SLTU: op = CU_SLTU;
                  F3_XOR:  op = CU_XOR;
                  F3_SR:   op = CU_SRL;
                  F3_OR:   op = CU_OR;
                  default: op = CU_AND;
               endcase
            end else if (f7 == F7_ALT) begin
               case (f3)
                  F3_ADD:  op = CU_SUB;
                  F3_SR:   op = CU_SRA;
                  default: op = CU_ERROR;
               endcase
            end
         default: op = CU_ERROR;
      endcase
   end

   // Immediate packing and register extraction driven by the instruction format.
   always_comb begin
      imm_o = 20'd0;
      rs1_o = 5'd0;
      rs2_o = 5'd0;
      rd_o  = 5'd0;
      case (fmt)
         FMT_U: begin
            imm_o = instr_i[31:12];
            rd_o  = instr_i[11:7];
         end
         FMT_I: begin
            imm_o = {8'd0, instr_i[31:20]};
            rs1_o = instr_i[19:15];
            rd_o  = instr_i[11:7];
         end
         FMT_SHAMT: begin
            imm_o = {15'd0, instr_i[24:20]};
            rs1_o = instr_i[19:15];
            rd_o  = instr_i[11:7];
         end
         FMT_S: begin
            imm_o = {8'd0, instr_i[31:25], instr_i[11:7]};
            rs1_o = instr_i[19:15];
            rs2_o = instr_i[24:20];
         end
         FMT_B: begin
            imm_o = {8'd0, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8]};
            rs1_o = instr_i[19:15];
            rs2_o = instr_i[24:20];
         end
         FMT_R: begin
            rs1_o = instr_i[19:15];
            rs2_o = instr_i[24:20];
            rd_o  = instr_i[11:7];
         end
         default: ;
      endcase
   end

   assign cu_op_o = op;

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: valid/ready input, output register plus one skid register,
// flush to kill in-flight entries. in_ready comes straight from a flop.
module decode_stage
   import cu_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int PC_W = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] instr,
   input  logic [PC_W-1:0] pc_in,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [5:0]      cu_op,
   output logic [19:0]     imm,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [4:0]      rd,
   output logic [PC_W-1:0] pc_out,
   output logic            illegal
);

   cu_op_e          cls_op;
   logic [19:0]     cls_imm;
   logic [4:0]      cls_rs1, cls_rs2, cls_rd;
   decoded_t        cls;
   decoded_t        main_q, main_d, skid_q;
   logic [PC_W-1:0] main_pc_q, main_pc_d, skid_pc_q;
   logic            main_v_q, main_v_d;
   logic            skid_v_q, skid_v_d;
   logic            in_ready_q;
   logic            accept, drain, load_skid;

   insn_classify u_classify (
      .instr_i (instr[31:0]),
      .cu_op_o (cls_op),
      .imm_o   (cls_imm),
      .rs1_o   (cls_rs1),
      .rs2_o   (cls_rs2),
      .rd_o    (cls_rd)
   );

   assign cls = '{cu_op: cls_op, imm: cls_imm, rs1: cls_rs1, rs2: cls_rs2, rd: cls_rd,
                  illegal: (cls_op == CU_ERROR)};

   assign accept = in_valid & in_ready_q;
   assign drain  = main_v_q & out_ready;

   // Skid control: refill main from skid or input, park input in skid when main stalls.
   always_comb begin
      main_v_d  = main_v_q;
      skid_v_d  = skid_v_q;
      main_d    = main_q;
      main_pc_d = main_pc_q;
      load_skid = 1'b0;
      if (flush) begin
         main_v_d = 1'b0;
         skid_v_d = 1'b0;
      end else if (!main_v_q || drain) begin
         if (skid_v_q) begin
            main_v_d  = 1'b1;
            main_d    = skid_q;
            main_pc_d = skid_pc_q;
            skid_v_d  = 1'b0;
         end else if (accept) begin
            main_v_d  = 1'b1;
            main_d    = cls;
            main_pc_d = pc_in;
         end else begin
            main_v_d  = 1'b0;
         end
      end else if (accept) begin
         skid_v_d  = 1'b1;
         load_skid = 1'b1;
      end
   end

   // Valid bits, ready flop and output register; reset wins over flush and handshakes.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop here samples pre-edge values.
      if (rst) begin
         main_v_q   <= 1'b0;
         skid_v_q   <= 1'b0;
         in_ready_q <= 1'b1;
         main_q     <= DECODED_RESET;
         main_pc_q  <= '0;
      end else begin
         main_v_q   <= main_v_d;
         skid_v_q   <= skid_v_d;
         in_ready_q <= !skid_v_d;
         main_q     <= main_d;
         main_pc_q  <= main_pc_d;
      end
   end

   // Skid payload capture when an input arrives while main is stalled.
   always_ff @(posedge clk) begin
      // NOTE: the skid payload has no reset; it is only ever read while skid_v_q is set.
      if (load_skid) begin
         skid_q    <= cls;
         skid_pc_q <= pc_in;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = main_v_q;
   assign cu_op     = main_q.cu_op;
   assign imm       = main_q.imm;
   assign rs1       = main_q.rs1;
   assign rs2       = main_q.rs2;
   assign rd        = main_q.rd;
   assign pc_out    = main_pc_q;
   assign illegal   = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus a randomized stream
// scored against a table-driven RV32I reference decoder.
module tb_decode_stage;
   import cu_pkg::*;

   logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready, illegal;
   logic [31:0] instr, pc_in, pc_out;
   logic [5:0]  cu_op;
   logic [19:0] imm;
   logic [4:0]  rs1, rs2, rd;
   logic [73:0] obs;

   int errors = 0;
   int checks = 0;

   decode_stage #(.XLEN(32), .PC_W(32)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .pc_in(pc_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .cu_op(cu_op), .imm(imm), .rs1(rs1), .rs2(rs2), .rd(rd),
      .pc_out(pc_out), .illegal(illegal)
   );

   assign obs = {cu_op, imm, rs1, rs2, rd, pc_out, illegal};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference decoder ----------------
   typedef enum {K_U, K_I, K_SH, K_S, K_B, K_R} kind_e;
   typedef struct packed {
      cu_op_e      op;
      logic [19:0] imm;
      logic [4:0]  rs1, rs2, rd;
   } exp_t;

   cu_op_e br_tab    [8] = '{CU_BEQ, CU_BNE, CU_ERROR, CU_ERROR, CU_BLT, CU_BGE, CU_BLTU, CU_BGEU};
   cu_op_e ld_tab    [8] = '{CU_LB, CU_LH, CU_LW, CU_ERROR, CU_LBU, CU_LHU, CU_ERROR, CU_ERROR};
   cu_op_e st_tab    [8] = '{CU_SB, CU_SH, CU_SW, CU_ERROR, CU_ERROR, CU_ERROR, CU_ERROR, CU_ERROR};
   cu_op_e opimm_tab [8] = '{CU_ADDI, CU_SLLI, CU_SLTI, CU_SLTIU, CU_XORI, CU_SRLI, CU_ORI, CU_ANDI};
   cu_op_e r_tab     [8] = '{CU_ADD, CU_SLL, CU_SLT, CU_SLTU, CU_XOR, CU_SRL, CU_OR, CU_AND};
   cu_op_e r_alt_tab [8] = '{CU_SUB, CU_ERROR, CU_ERROR, CU_ERROR, CU_ERROR, CU_SRA, CU_ERROR, CU_ERROR};
   logic [6:0] legal_opc [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};

   function automatic exp_t ref_decode(logic [31:0] w);
      exp_t        e;
      kind_e       k;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [12:0] boff;
      f3 = w[14:12];
      f7 = w[31:25];
      e  = '{op: CU_ERROR, imm: 20'd0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0};
      k  = K_R;
      case (w[6:0])
         7'h37: begin e.op = CU_LUI;   k = K_U; end
         7'h17: begin e.op = CU_AUIPC; k = K_U; end
         7'h6F: begin e.op = CU_JAL;   k = K_U; end
         7'h67: begin if (f3 == 3'd0) e.op = CU_JALR; k = K_I; end
         7'h63: begin e.op = br_tab[f3]; k = K_B; end
         7'h03: begin e.op = ld_tab[f3]; k = K_I; end
         7'h23: begin e.op = st_tab[f3]; k = K_S; end
         7'h13: begin
            e.op = opimm_tab[f3];
            k = K_I;
            if (f3 == 3'd1 || f3 == 3'd5) begin
               k = K_SH;
               if (f3 == 3'd5 && f7 == 7'h20) e.op = CU_SRAI;
               else if (f7 != 7'h00)          e.op = CU_ERROR;
            end
         end
         7'h33: begin
            k = K_R;
            if (f7 == 7'h00)      e.op = r_tab[f3];
            else if (f7 == 7'h20) e.op = r_alt_tab[f3];
            else                  e.op = CU_ERROR;
         end
         default: e.op = CU_ERROR;
      endcase
      if (e.op == CU_ERROR) return e;
      // Branch offset in bytes (bit 0 always zero); the packed field is offset[12:1].
      boff = {w[31], w[7], w[30:25], w[11:8], 1'b0};
      case (k)
         K_U:     e.imm = w[31:12];
         K_I:     e.imm = 20'(w[31:20]);
         K_SH:    e.imm = 20'(w[24:20]);
         K_S:     e.imm = 20'({w[31:25], w[11:7]});
         K_B:     e.imm = 20'(boff[12:1]);
         default: e.imm = 20'd0;
      endcase
      if (k != K_U)                                 e.rs1 = w[19:15];
      if (k == K_S || k == K_B || k == K_R)         e.rs2 = w[24:20];
      if (k != K_S && k != K_B)                     e.rd  = w[11:7];
      return e;
   endfunction

   function automatic logic [73:0] exp_bits(logic [31:0] w, logic [31:0] p);
      exp_t e;
      e = ref_decode(w);
      return {e.op, e.imm, e.rs1, e.rs2, e.rd, p, (e.op == CU_ERROR)};
   endfunction

   task automatic gen_legal(output logic [31:0] w);
      exp_t e;
      for (int tries = 0; tries < 64; tries++) begin
         w = $urandom;
         w[6:0] = legal_opc[$urandom_range(0, 8)];
         if (w[6:0] == 7'h33 || (w[6:0] == 7'h13 && w[13:12] == 2'b01))
            w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
         e = ref_decode(w);
         if (e.op != CU_ERROR) return;
      end
      w = 32'h0000_0013;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
      in_valid = 1'b1; instr = 32'h0000_0013; pc_in = 32'h40;
      tick();
      tick();
      rst = 1'b0; in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0)
         begin errors++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
      checks++; if (in_ready !== 1'b1)
         begin errors++; $display("FAIL reset_in_ready: got %b, expected 1", in_ready); end
      checks++; if (cu_op !== CU_ERROR)
         begin errors++; $display("FAIL reset_cu_op: got %0d, expected %0d", cu_op, CU_ERROR); end
      checks++; if ({imm, rs1, rs2, rd, pc_out, illegal} !== 68'd0)
         begin errors++; $display("FAIL reset_fields: got %h, expected 0", {imm, rs1, rs2, rd, pc_out, illegal}); end
      tick();
      checks++; if ({out_valid, in_ready} !== 2'b01)
         begin errors++; $display("FAIL reset_idle: got valid/ready %b, expected 01", {out_valid, in_ready}); end
   endtask

   task automatic test_decode();
      logic [73:0] exp;
      out_ready = 1'b1;
      in_valid = 1'b1; instr = 32'hFE00_0EE3; pc_in = 32'h100;    // beq x0,x0,-4
      tick();
      instr = 32'h0080_00EF; pc_in = 32'h104;                      // jal x1,8
      exp = {CU_BEQ, 20'h00FFE, 5'd0, 5'd0, 5'd0, 32'h100, 1'b0};
      checks++; if (out_valid !== 1'b1 || obs !== exp)
         begin errors++; $display("FAIL decode_beq: got v=%b %h, expected v=1 %h", out_valid, obs, exp); end
      tick();
      in_valid = 1'b0;
      exp = {CU_JAL, 20'h00800, 5'd0, 5'd0, 5'd1, 32'h104, 1'b0};
      checks++; if (out_valid !== 1'b1 || obs !== exp)
         begin errors++; $display("FAIL decode_jal: got v=%b %h, expected v=1 %h", out_valid, obs, exp); end
      tick();
      checks++; if (out_valid !== 1'b0)
         begin errors++; $display("FAIL decode_drained: got %b, expected 0", out_valid); end
   endtask

   task automatic test_backpressure();
      logic [31:0] w [3];
      logic [31:0] p [3];
      int got, first_c, last_c;
      logic acc;
      for (int i = 0; i < 3; i++) begin gen_legal(w[i]); p[i] = 32'h1000 + 32'(i * 4); end
      out_ready = 1'b0;
      in_valid = 1'b1; instr = w[0]; pc_in = p[0];
      tick();
      instr = w[1]; pc_in = p[1];
      checks++; if (in_ready !== 1'b1)
         begin errors++; $display("FAIL bp_ready_second: got %b, expected 1", in_ready); end
      tick();
      instr = w[2]; pc_in = p[2];
      tick();
      tick();
      checks++; if (in_ready !== 1'b0)
         begin errors++; $display("FAIL bp_ready_third: got %b, expected 0", in_ready); end
      checks++; if (out_valid !== 1'b1 || obs !== exp_bits(w[0], p[0]))
         begin errors++; $display("FAIL bp_hold: got v=%b %h, expected v=1 %h", out_valid, obs, exp_bits(w[0], p[0])); end
      out_ready = 1'b1;
      got = 0; first_c = 0; last_c = 0;
      for (int c = 0; c < 10 && got < 3; c++) begin
         if (out_valid) begin
            checks++; if (obs !== exp_bits(w[got], p[got]))
               begin errors++; $display("FAIL bp_order_%0d: got %h, expected %h", got, obs, exp_bits(w[got], p[got])); end
            if (got == 0) first_c = c;
            last_c = c;
            got++;
         end
         acc = in_valid && in_ready;
         tick();
         if (acc) in_valid = 1'b0;
      end
      checks++; if (got !== 3 || last_c - first_c !== 2)
         begin errors++; $display("FAIL bp_release: got %0d outputs over %0d cycles, expected 3 over 3", got, last_c - first_c + 1); end
      checks++; if (out_valid !== 1'b0 || in_valid !== 1'b0)
         begin errors++; $display("FAIL bp_extra: got v=%b pending=%b, expected 0 0", out_valid, in_valid); end
   endtask

   task automatic test_flush();
      logic [31:0] wa, wb, wd, we, wf, wg;
      int seen;
      gen_legal(wa); gen_legal(wb); gen_legal(wd); gen_legal(we); gen_legal(wf); gen_legal(wg);
      // Main and skid full, input offered during flush.
      out_ready = 1'b0;
      in_valid = 1'b1; instr = wa; pc_in = 32'h2000;
      tick();
      instr = wb; pc_in = 32'h2004;
      tick();
      instr = wd; pc_in = 32'h2008; flush = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      checks++; if ({out_valid, in_ready} !== 2'b01)
         begin errors++; $display("FAIL flush_full_state: got valid/ready %b, expected 01", {out_valid, in_ready}); end
      checks++; if (obs !== exp_bits(wa, 32'h2000))
         begin errors++; $display("FAIL flush_fields_hold: got %h, expected %h", obs, exp_bits(wa, 32'h2000)); end
      out_ready = 1'b1;
      seen = 0;
      for (int c = 0; c < 4; c++) begin if (out_valid) seen++; tick(); end
      checks++; if (seen !== 0)
         begin errors++; $display("FAIL flush_full_leak: got %0d outputs, expected 0", seen); end
      // Only main full; the input accepted in the flush cycle must vanish.
      out_ready = 1'b0;
      in_valid = 1'b1; instr = we; pc_in = 32'h3000;
      tick();
      instr = wf; pc_in = 32'h3004; flush = 1'b1;
      checks++; if (in_ready !== 1'b1)
         begin errors++; $display("FAIL flush_accept_ready: got %b, expected 1", in_ready); end
      tick();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      checks++; if ({out_valid, in_ready} !== 2'b01)
         begin errors++; $display("FAIL flush_accept_state: got valid/ready %b, expected 01", {out_valid, in_ready}); end
      seen = 0;
      for (int c = 0; c < 3; c++) begin if (out_valid) seen++; tick(); end
      checks++; if (seen !== 0)
         begin errors++; $display("FAIL flush_accept_leak: got %0d outputs, expected 0", seen); end
      in_valid = 1'b1; instr = wg; pc_in = 32'h3008;
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || obs !== exp_bits(wg, 32'h3008))
         begin errors++; $display("FAIL flush_recover: got v=%b %h, expected v=1 %h", out_valid, obs, exp_bits(wg, 32'h3008)); end
      tick();
   endtask

   task automatic test_illegal();
      logic [31:0] ws [3];
      ws[0] = 32'h0000_007F; ws[1] = 32'h4000_1033; ws[2] = 32'h00A3_0293;   // bad opcode, sll f7b5, addi x5,x6,10
      out_ready = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         instr = ws[i]; pc_in = 32'h4000 + 32'(i * 4);
         tick();
         checks++; if (out_valid !== 1'b1 || in_ready !== 1'b1 || obs !== exp_bits(ws[i], 32'h4000 + 32'(i * 4)))
            begin errors++; $display("FAIL illegal_flow_%0d: got v=%b r=%b %h, expected v=1 r=1 %h",
                                     i, out_valid, in_ready, obs, exp_bits(ws[i], 32'h4000 + 32'(i * 4))); end
         if (i < 2) begin
            checks++; if (cu_op !== CU_ERROR || illegal !== 1'b1 || {imm, rs1, rs2, rd} !== 35'd0)
               begin errors++; $display("FAIL illegal_fields_%0d: got op=%0d ill=%b imm=%h, expected op=%0d ill=1 imm=0",
                                        i, cu_op, illegal, imm, CU_ERROR); end
         end
      end
      in_valid = 1'b0;
      checks++; if (cu_op !== CU_ADDI || imm !== 20'h0000A || rs1 !== 5'd6 || rd !== 5'd5)
         begin errors++; $display("FAIL illegal_then_addi: got op=%0d imm=%h rs1=%0d rd=%0d, expected op=%0d imm=0000a rs1=6 rd=5",
                                  cu_op, imm, rs1, rd, CU_ADDI); end
      tick();
   endtask

   task automatic test_stream();
      logic [73:0] sbq [$];
      logic [73:0] e;
      logic [31:0] w;
      int sent, received;
      logic acc;
      sent = 0; received = 0;
      in_valid = 1'b0;
      for (int c = 0; c < 3000 && received < 100; c++) begin
         if (!in_valid && sent < 100 && $urandom_range(0, 3) != 0) begin
            gen_legal(w);
            instr = w; pc_in = $urandom; in_valid = 1'b1;
         end
         out_ready = ($urandom_range(0, 2) != 0);
         checks++; if ({out_valid, in_ready} !== {sbq.size() > 0, sbq.size() < 2})
            begin errors++; $display("FAIL stream_flow_c%0d: got valid/ready %b, expected %b", c,
                                     {out_valid, in_ready}, {sbq.size() > 0, sbq.size() < 2}); end
         if (out_valid && out_ready && sbq.size() > 0) begin
            e = sbq.pop_front();
            checks++; if (obs !== e)
               begin errors++; $display("FAIL stream_data_%0d: got %h, expected %h", received, obs, e); end
            received++;
         end
         acc = in_valid && in_ready;
         if (acc) begin sbq.push_back(exp_bits(instr, pc_in)); sent++; end
         tick();
         if (acc) in_valid = 1'b0;
      end
      in_valid = 1'b0;
      checks++; if (received !== 100)
         begin errors++; $display("FAIL stream_count: got %0d entries, expected 100", received); end
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      instr = 32'd0; pc_in = 32'd0;
      test_reset();
      test_decode();
      test_backpressure();
      test_flush();
      test_illegal();
      test_stream();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
